// File: rtl/reg_file_cc_pkg.sv
// Shared constants and types for the LC-3 register file and condition-code logic.
package reg_file_cc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 1 << ADDR_W;
  localparam int IMM5_W = 5;

  // Condition code, packed in architectural order {N, Z, P}
  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam logic [2:0] NZP_RESET = 3'b010;

endpackage : reg_file_cc_pkg

// File: rtl/reg_file_cc_nzp_gen.sv
// Combinational condition-code generator: classifies a bus word as negative, zero or positive.
// Kept standalone so the PSR logic can reuse it.
module nzp_gen
  import reg_file_cc_pkg::*;
#(
  parameter int DATA_W = reg_file_cc_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] bus,
  output nzp_t              nzp
);

  logic signed [DATA_W-1:0] bus_s;
  logic                     is_zero;

  assign bus_s   = $signed(bus);
  assign is_zero = (bus == '0);

  // Exactly one flag is set for any input word
  always_comb begin
    nzp   = '0;
    nzp.n = (bus_s < 0);
    nzp.z = is_zero;
    nzp.p = (bus_s > 0);
  end

endmodule : nzp_gen

// File: rtl/reg_file_cc.sv
// LC-3 general-purpose register file with NZP condition codes and branch enable.
// Reads are combinational with no write bypass; all state updates on the rising clock edge.
module reg_file_cc
  import reg_file_cc_pkg::*;
#(
  parameter int DATA_W = reg_file_cc_pkg::DATA_W,
  parameter int NREGS  = reg_file_cc_pkg::NREGS,
  parameter int ADDR_W = reg_file_cc_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] DR,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  input  logic [DATA_W-1:0] BUS,
  input  logic [5:0]        IR_5_0,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic [2:0]        IR_11_9,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2MUX_OUT,
  output logic              N,
  output logic              Z,
  output logic              P,
  output logic              BEN
);

  // Sign-extend the 5-bit immediate field to the datapath width
  function automatic logic signed [DATA_W-1:0] sext_imm5(input logic signed [IMM5_W-1:0] imm);
    return DATA_W'(imm);
  endfunction

  logic [DATA_W-1:0] gpr [NREGS];
  nzp_t              nzp_q;
  nzp_t              nzp_bus;
  logic              ben_q;
  logic              ben_next;
  logic [DATA_W-1:0] sr2_reg;
  logic [DATA_W-1:0] imm_ext;

  nzp_gen #(
    .DATA_W (DATA_W)
  ) u_nzp_gen (
    .bus (BUS),
    .nzp (nzp_bus)
  );

  // Register array write port; reset clears every register and overrides LD_REG
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr[i] <= '0;
      end
    end else if (LD_REG) begin
      gpr[DR] <= BUS;
    end
  end

  // Branch enable uses the condition code held before this edge
  always_comb begin
    ben_next = ben_q;
    if (LD_BEN) begin
      ben_next = |(IR_11_9 & nzp_q);
    end
  end

  // Condition-code and branch-enable state; loads are independent of each other
  always_ff @(posedge CLK) begin
    if (RESET) begin
      nzp_q <= NZP_RESET;
      ben_q <= 1'b0;
    end else begin
      if (LD_CC) begin
        nzp_q <= nzp_bus;
      end
      ben_q <= ben_next;
    end
  end

  // Zero-latency read ports and the SR2/immediate operand select feeding ALU.B
  always_comb begin
    SR1_OUT    = gpr[SR1];
    sr2_reg    = gpr[SR2];
    imm_ext    = $unsigned(sext_imm5($signed(IR_5_0[IMM5_W-1:0])));
    SR2MUX_OUT = IR_5_0[5] ? imm_ext : sr2_reg;
  end

  assign N   = nzp_q.n;
  assign Z   = nzp_q.z;
  assign P   = nzp_q.p;
  assign BEN = ben_q;

endmodule : reg_file_cc

// File: tb/tb_reg_file_cc.sv
// Directed bench for reg_file_cc: reset, write/read timing, NZP, SR2MUX, BEN and reset override.
module tb_reg_file_cc;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LD_REG;
  logic [2:0]  DR;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic [15:0] BUS;
  logic [5:0]  IR_5_0;
  logic        LD_CC;
  logic        LD_BEN;
  logic [2:0]  IR_11_9;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2MUX_OUT;
  logic        N;
  logic        Z;
  logic        P;
  logic        BEN;

  int errors = 0;
  int checks = 0;

  reg_file_cc dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .LD_REG     (LD_REG),
    .DR         (DR),
    .SR1        (SR1),
    .SR2        (SR2),
    .BUS        (BUS),
    .IR_5_0     (IR_5_0),
    .LD_CC      (LD_CC),
    .LD_BEN     (LD_BEN),
    .IR_11_9    (IR_11_9),
    .SR1_OUT    (SR1_OUT),
    .SR2MUX_OUT (SR2MUX_OUT),
    .N          (N),
    .Z          (Z),
    .P          (P),
    .BEN        (BEN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    LD_REG = 1'b1;
    DR     = idx;
    BUS    = val;
    tick();
    LD_REG = 1'b0;
  endtask

  initial begin
    RESET   = 1'b1;
    LD_REG  = 1'b0;
    DR      = '0;
    SR1     = '0;
    SR2     = '0;
    BUS     = '0;
    IR_5_0  = '0;
    LD_CC   = 1'b0;
    LD_BEN  = 1'b0;
    IR_11_9 = '0;

    // Reset state
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      SR2 = 3'(7 - i);
      #1;
      check($sformatf("reset_sr1_r%0d", i), SR1_OUT, 16'h0000);
      check($sformatf("reset_sr2_r%0d", 7 - i), SR2MUX_OUT, 16'h0000);
    end
    check("reset_nzp", {13'd0, N, Z, P}, 16'h0002);
    check("reset_ben", {15'd0, BEN}, 16'h0000);

    // Write with same-cycle read: old value before the edge, new after
    LD_REG = 1'b1;
    DR     = 3'd3;
    BUS    = 16'hBEEF;
    SR1    = 3'd3;
    #1;
    check("wr_pre_edge", SR1_OUT, 16'h0000);
    tick();
    LD_REG = 1'b0;
    check("wr_post_edge", SR1_OUT, 16'hBEEF);
    SR1 = 3'd2;
    #1;
    check("wr_other_reg", SR1_OUT, 16'h0000);

    // Condition codes from the bus
    LD_CC = 1'b1;
    BUS   = 16'h8000;
    tick();
    check("cc_neg", {13'd0, N, Z, P}, 16'h0004);
    BUS = 16'h0000;
    tick();
    check("cc_zero", {13'd0, N, Z, P}, 16'h0002);
    BUS = 16'h0001;
    tick();
    check("cc_pos", {13'd0, N, Z, P}, 16'h0001);
    BUS = 16'h7FFF;
    tick();
    check("cc_maxpos", {13'd0, N, Z, P}, 16'h0001);
    LD_CC = 1'b0;
    BUS   = 16'h8000;
    tick();
    check("cc_hold", {13'd0, N, Z, P}, 16'h0001);

    // SR2MUX: immediate vs register operand
    write_reg(3'd5, 16'h1234);
    SR2    = 3'd5;
    IR_5_0 = 6'b110000;
    #1;
    check("mux_imm_neg", SR2MUX_OUT, 16'hFFF0);
    IR_5_0 = 6'b101111;
    #1;
    check("mux_imm_pos", SR2MUX_OUT, 16'h000F);
    IR_5_0 = 6'b001111;
    #1;
    check("mux_reg", SR2MUX_OUT, 16'h1234);
    IR_5_0 = 6'b011111;
    #1;
    check("mux_reg_b4set", SR2MUX_OUT, 16'h1234);

    // BEN samples old NZP (currently P) while NZP loads N in the same edge
    LD_CC   = 1'b1;
    BUS     = 16'h8000;
    LD_BEN  = 1'b1;
    IR_11_9 = 3'b001;
    tick();
    check("ben_old_p", {15'd0, BEN}, 16'h0001);
    check("ben_nzp_new", {13'd0, N, Z, P}, 16'h0004);
    tick();
    check("ben_repeat", {15'd0, BEN}, 16'h0000);
    LD_CC   = 1'b0;
    IR_11_9 = 3'b100;
    tick();
    check("ben_n_mask", {15'd0, BEN}, 16'h0001);
    LD_BEN  = 1'b0;
    IR_11_9 = 3'b000;
    tick();
    check("ben_hold", {15'd0, BEN}, 16'h0001);

    // Aliased DR/SR1/SR2 during a write
    IR_5_0 = 6'b000000;
    LD_REG = 1'b1;
    DR     = 3'd2;
    SR1    = 3'd2;
    SR2    = 3'd2;
    BUS    = 16'hA5A5;
    #1;
    check("alias_sr1_pre", SR1_OUT, 16'h0000);
    check("alias_sr2_pre", SR2MUX_OUT, 16'h0000);
    tick();
    LD_REG = 1'b0;
    check("alias_sr1_post", SR1_OUT, 16'hA5A5);
    check("alias_sr2_post", SR2MUX_OUT, 16'hA5A5);

    // Fill R0..R7 then confirm contents; also confirm hold with no load
    for (int i = 0; i < 8; i++) begin
      write_reg(3'(i), 16'(16'h1111 * i));
    end
    BUS = 16'hDEAD;
    tick();
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      #1;
      check($sformatf("fill_r%0d", i), SR1_OUT, 16'(16'h1111 * i));
    end

    // Reset overrides every concurrent load
    RESET   = 1'b1;
    LD_REG  = 1'b1;
    DR      = 3'd7;
    BUS     = 16'h0001;
    LD_CC   = 1'b1;
    LD_BEN  = 1'b1;
    IR_11_9 = 3'b111;
    tick();
    RESET  = 1'b0;
    LD_REG = 1'b0;
    LD_CC  = 1'b0;
    LD_BEN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      #1;
      check($sformatf("rst_mid_r%0d", i), SR1_OUT, 16'h0000);
    end
    check("rst_mid_nzp", {13'd0, N, Z, P}, 16'h0002);
    check("rst_mid_ben", {15'd0, BEN}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file_cc
